servgrid_heartbeat_mon: RTL and testbench

//  Synthesisable per-core liveness monitor for a servgrid array of NCORES SERV cores.

---
 rtl/servgrid_heartbeat_mon.sv | 197 +++++++++++++++++++
 tb/tb_servgrid_heartbeat_mon.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/servgrid_heartbeat_mon.sv
// ---------------------------------------------------------------------------
// servgrid_heartbeat_mon
//
// Per-core liveness monitor for a servgrid array of SERV cores. Each core's
// q (GPIO/blinky) line is edge-detected. A saturating counter records the
// toggles on each channel, and an idle timer measures the time since the
// last toggle. A channel that stays idle for TIMEOUT cycles is flagged as
// stuck, and a sticky error bit is latched for it. The status and counters
// are exposed on a Wishbone-classic slave. o_irq is a registered OR of the
// latched error bits.
//
// Ports
//   wb_clk    : system clock. i_q is synchronous to this clock.
//   wb_rst    : asynchronous, active-high reset. Clears all state.
//   i_q       : q outputs from servgrid. Bit n corresponds to core n.
//   i_wb_adr  : byte address. Only bits [7:2] (the word index) are decoded.
//   i_wb_dat  : write data.
//   i_wb_we   : write enable.
//   i_wb_stb  : strobe. cyc is implied by stb.
//   o_wb_rdt  : read data. Valid together with o_wb_ack.
//   o_wb_ack  : single-cycle acknowledge.
//   o_stuck   : live stuck vector, one bit per channel.
//   o_irq     : registered OR of the err bits.
//
// Register map (word index), unused bits read 0
//   0       stuck        RO
//   1       err          W1C per bit
//   2       alive        RO
//   3       ID           RO  {8'h5B, NCORES, CNT_W, 8'h01}
//   4+n     cnt[n]       RW  Any write clears the counter.
//                            Words with n >= NCORES read as 0.
// ---------------------------------------------------------------------------
module servgrid_heartbeat_mon #(
    parameter int NCORES  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 100000,
    parameter int TO_W    = 24
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [NCORES-1:0] i_q,
    input  logic [31:0]       i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic              i_wb_we,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_rdt,
    output logic              o_wb_ack,
    output logic [NCORES-1:0] o_stuck,
    output logic              o_irq
);

    localparam logic [31:0]     ID_WORD   = {8'h5B, 8'(NCORES), 8'(CNT_W), 8'h01};
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_PRE    = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NCORES-1:0]             q_prev_q;
    logic [NCORES-1:0][CNT_W-1:0]  cnt_q,   cnt_d;
    logic [NCORES-1:0][TO_W-1:0]   timer_q, timer_d;
    logic [NCORES-1:0]             stuck_q, stuck_d;
    logic [NCORES-1:0]             err_q,   err_d;
    logic [NCORES-1:0]             alive_q, alive_d;
    logic                          ack_q,   ack_d;
    logic [31:0]                   rdt_q,   rdt_d;
    logic                          irq_q;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    // An access is performed on the cycle in which ack is being raised. This
    // cycle is the clock edge that registers ack_d = 1. Holding stb high
    // therefore produces an access on every other cycle.
    logic       access;
    logic       wr_en;
    logic [5:0] word;
    logic [NCORES-1:0] err_clr;
    logic [NCORES-1:0] cnt_clr;
    logic [NCORES-1:0] edge_det;
    logic [NCORES-1:0] stuck_set;

    assign access = i_wb_stb & ~ack_q;
    assign wr_en  = access & i_wb_we;
    assign word   = i_wb_adr[7:2];

    assign err_clr  = (wr_en && word == 6'd1) ? i_wb_dat[NCORES-1:0] : '0;
    assign edge_det = i_q ^ q_prev_q;

    // The address bits outside [7:2] are not decoded. The data bits above
    // NCORES are not used either.
    logic unused_bits;
    assign unused_bits = ^{i_wb_adr[31:8], i_wb_adr[1:0], i_wb_dat};

    // -----------------------------------------------------------------------
    // Per-channel next state
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        stuck_d   = stuck_q;
        alive_d   = alive_q;
        cnt_clr   = '0;
        stuck_set = '0;
        for (int n = 0; n < NCORES; n++) begin
            cnt_clr[n] = wr_en && (word == 6'(4 + n));

            // A counter clear on the same cycle as an edge keeps that edge.
            if (cnt_clr[n]) begin
                cnt_d[n] = edge_det[n] ? CNT_W'(1) : '0;
            end else if (edge_det[n] && cnt_q[n] != CNT_FULL) begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end

            // The timer is one step away from TIMEOUT and no edge arrived.
            // stuck rises together with the timer reaching TIMEOUT, which
            // gives exactly TIMEOUT cycles of detection latency. The timer
            // then holds at TIMEOUT, so this condition can only pulse once
            // per idle period.
            stuck_set[n] = !edge_det[n] && (timer_q[n] == TO_PRE);

            if (edge_det[n]) begin
                timer_d[n] = '0;
                stuck_d[n] = 1'b0;
                alive_d[n] = 1'b1;
            end else begin
                if (timer_q[n] != TO_MAX) begin
                    timer_d[n] = timer_q[n] + TO_W'(1);
                end
                if (stuck_set[n]) begin
                    stuck_d[n] = 1'b1;
                end
            end
        end
    end

    // A set of an err bit wins over a W1C clear that arrives on the same cycle.
    assign err_d = (err_q & ~err_clr) | stuck_set;

    // -----------------------------------------------------------------------
    // Read mux (returns pre-update values)
    // -----------------------------------------------------------------------
    always_comb begin
        rdt_d = rdt_q;
        ack_d = i_wb_stb & ~ack_q;
        if (access) begin
            rdt_d = '0;
            case (word)
                6'd0: rdt_d[NCORES-1:0] = stuck_q;
                6'd1: rdt_d[NCORES-1:0] = err_q;
                6'd2: rdt_d[NCORES-1:0] = alive_q;
                6'd3: rdt_d             = ID_WORD;
                default: begin
                    for (int n = 0; n < NCORES; n++) begin
                        if (word == 6'(4 + n)) begin
                            rdt_d[CNT_W-1:0] = cnt_q[n];
                        end
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            q_prev_q <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            stuck_q  <= '0;
            err_q    <= '0;
            alive_q  <= '0;
            ack_q    <= 1'b0;
            rdt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            q_prev_q <= i_q;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            stuck_q  <= stuck_d;
            err_q    <= err_d;
            alive_q  <= alive_d;
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            irq_q    <= |err_q;
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = ack_q;
    assign o_stuck  = stuck_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_servgrid_heartbeat_mon.sv
module tb_servgrid_heartbeat_mon;

    localparam logic [31:0] ID_EXP = 32'h5B04_0401;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  q;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic        stb;
    logic [31:0] rdt;
    logic        ack;
    logic [3:0]  stuck;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servgrid_heartbeat_mon #(
        .NCORES  (4),
        .CNT_W   (4),
        .TIMEOUT (50),
        .TO_W    (8)
    ) dut (
        .wb_clk   (clk),
        .wb_rst   (rst),
        .i_q      (q),
        .i_wb_adr (adr),
        .i_wb_dat (dat),
        .i_wb_we  (we),
        .i_wb_stb (stb),
        .o_wb_rdt (rdt),
        .o_wb_ack (ack),
        .o_stuck  (stuck),
        .o_irq    (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        adr = a; we = 1'b0; stb = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(ack), 32'd1);
        check(tag, rdt, exp);
        stb = 1'b0;
        tick();
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        adr = a; dat = d; we = 1'b1; stb = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(ack), 32'd1);
        stb = 1'b0; we = 1'b0;
        tick();
    endtask

    // Reset is released 1 time unit after a rising edge. The next rising
    // edge is therefore cycle 1 after release.
    task automatic do_reset();
        rst = 1'b1; q = '0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; q = '0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;

        // ---- reset state ----
        #2;
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_stuck", 32'(stuck), 32'd0);
        check("rst_irq",   32'(irq),   32'd0);
        check("rst_rdt",   rdt,        32'd0);

        // ---- 1: ch0 toggles 10 times, finished well before the timeout ----
        do_reset();
        for (int k = 0; k < 10; k++) begin
            q[0] = ~q[0];
            for (int c = 0; c < 4; c++) tick();
        end
        wb_read(32'h10, 32'd10, "s1_cnt0");
        wb_read(32'h14, 32'd0,  "s1_cnt1");
        wb_read(32'h08, 32'h1,  "s1_alive");
        check("s1_irq",   32'(irq),   32'd0);
        check("s1_stuck", 32'(stuck), 32'd0);

        // ---- 2: ch1 held low, the other channels kept alive ----
        do_reset();
        for (int i = 0; i < 49; i++) begin
            if (i % 10 == 9) q = q ^ 4'b1101;
            tick();
        end
        check("s2_stuck_49", 32'(stuck), 32'd0);
        tick();
        check("s2_stuck_50", 32'(stuck), 32'h2);
        check("s2_irq_50",   32'(irq),   32'd0);
        tick();
        check("s2_irq_51",   32'(irq),   32'd1);
        wb_read(32'h04, 32'h2, "s2_err");

        // ---- 3: ch1 toggles, then err is cleared with W1C ----
        q[1] = 1'b1;
        tick();
        check("s3_stuck_clr", 32'(stuck), 32'd0);
        check("s3_irq_hold",  32'(irq),   32'd1);
        wb_write(32'h04, 32'h2, "s3_w1c");
        check("s3_irq_drop",  32'(irq),   32'd0);
        wb_read(32'h04, 32'h0, "s3_err");
        wb_write(32'h08, 32'hFFFF_FFFF, "s3_wr_ro");
        wb_read(32'h08, 32'hF, "s3_alive");
        wb_read(32'h00, 32'h0, "s3_stuck_reg");

        // ---- 4: counter saturation and clear colliding with an edge ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            q[2] = ~q[2];
            tick();
        end
        wb_read(32'h18, 32'd15, "s4_sat");
        adr = 32'h18; dat = 32'h0; we = 1'b1; stb = 1'b1; q[2] = ~q[2];
        tick();
        check("s4_clr_ack", 32'(ack), 32'd1);
        stb = 1'b0; we = 1'b0;
        tick();
        wb_read(32'h18, 32'd1, "s4_clr_edge");
        // A read on the same cycle as an edge returns the pre-update value.
        adr = 32'h18; we = 1'b0; stb = 1'b1; q[2] = ~q[2];
        tick();
        check("s4_rd_pre", rdt, 32'd1);
        stb = 1'b0;
        tick();
        wb_read(32'h18, 32'd2, "s4_rd_post");
        wb_read(32'h1C, 32'd0, "s4_cnt3");
        wb_write(32'h20, 32'h5, "s4_wr_oob");
        wb_read(32'h20, 32'd0, "s4_rd_oob");

        // ---- 5: stb held high for 4 cycles on the ID register ----
        adr = 32'h0C; we = 1'b0; stb = 1'b1;
        check("s5_ack0", 32'(ack), 32'd0);
        tick();
        check("s5_ack1", 32'(ack), 32'd1);
        check("s5_id1",  rdt,      ID_EXP);
        tick();
        check("s5_ack2", 32'(ack), 32'd0);
        tick();
        check("s5_ack3", 32'(ack), 32'd1);
        check("s5_id3",  rdt,      ID_EXP);
        stb = 1'b0;
        tick();
        check("s5_ack4", 32'(ack), 32'd0);

        // ---- 6: asynchronous reset during a pending access ----
        for (int i = 0; i < 100 && !stuck[0]; i++) tick();
        check("s6_stuck_wait", 32'(stuck[0]), 32'd1);
        tick();
        check("s6_irq_pre", 32'(irq), 32'd1);
        adr = 32'h10; we = 1'b0; stb = 1'b1;
        tick();
        check("s6_ack_pre", 32'(ack), 32'd1);
        rst = 1'b1;
        #1;
        check("s6_ack_async",   32'(ack),   32'd0);
        check("s6_stuck_async", 32'(stuck), 32'd0);
        check("s6_irq_async",   32'(irq),   32'd0);
        stb = 1'b0; q = '0;
        tick();
        rst = 1'b0;
        wb_read(32'h10, 32'd0, "s6_cnt0");
        wb_read(32'h14, 32'd0, "s6_cnt1");
        wb_read(32'h18, 32'd0, "s6_cnt2");
        wb_read(32'h1C, 32'd0, "s6_cnt3");
        wb_read(32'h04, 32'd0, "s6_err");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
